// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
package hazard_pkg;

  localparam int REG_W           = 5;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_DONE = 2'b10,
    ERROR    = 2'b11
  } state_t;

endpackage

// File: rtl/mem_stall_fsm.sv
// Data-memory access sequencer: req/ack handshake with timeout, drives the
// pipeline freeze and the sticky error flag.
module mem_stall_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mem_op,
  input  logic mem_ack,
  output logic mem_req,
  output logic hold,
  output logic err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          req_reg, req_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      tmo_reg   <= '0;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    hold       = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_op) begin
          hold = 1'b1;
          if (start) begin
            state_next = MEM_WAIT;
            tmo_next   = '0;
          end
        end
      end
      MEM_WAIT: begin
        hold = 1'b1;
        if (start) begin
          // An ack on the final allowed cycle still completes the access.
          if (mem_ack) begin
            state_next = MEM_DONE;
            tmo_next   = '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_next = ERROR;
            tmo_next   = '0;
          end else begin
            tmo_next = tmo_reg + TW'(1);
          end
        end
      end
      MEM_DONE: begin
        if (start) state_next = RUN;
      end
      ERROR: begin
        hold = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    req_next = (state_next == MEM_WAIT);
  end

  assign mem_req = req_reg;
  assign err     = (state_reg == ERROR);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory
// freeze via mem_stall_fsm, and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] IDrs1_i,
  input  logic [REG_W-1:0] IDrs2_i,
  input  logic [REG_W-1:0] EXrd_i,
  input  logic             EXMemRead_i,
  input  logic             BranchTaken_i,
  input  logic             MEMMemRead_i,
  input  logic             MEMMemWrite_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             Stall_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             pipe_hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             hold;
  logic             err;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_reg;

  mem_stall_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_fsm (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (start_i),
    .mem_op  (MEMMemRead_i | MEMMemWrite_i),
    .mem_ack (mem_ack_i),
    .mem_req (mem_req_o),
    .hold    (hold),
    .err     (err)
  );

  assign load_use = EXMemRead_i && (EXrd_i != '0) &&
                    ((EXrd_i == IDrs1_i) || (EXrd_i == IDrs2_i));

  // A frozen pipeline takes no bubble; a load-use stall defers any branch.
  always_comb begin
    Stall_o     = 1'b0;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    IFIDFlush_o = 1'b0;
    pipe_hold_o = 1'b0;
    if (start_i) begin
      if (hold) begin
        pipe_hold_o = 1'b1;
      end else if (load_use) begin
        Stall_o = 1'b1;
      end else if (BranchTaken_i) begin
        IFIDFlush_o = 1'b1;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_reg <= '0;
    end else if (start_i && !PCWrite_o && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign err_o       = err;
  assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage RISC-V core.
- Detects load-use hazards and taken-branch flushes in ID.
- Sequences multi-cycle data-memory accesses in MEM through a req/ack handshake with a timeout.
- Drives the Control unit's Stall_i, the PC and IF/ID write enables, and a global pipeline freeze. Keeps a stall-cycle performance counter.

Parameters:
- TIMEOUT, 64: max MEM_WAIT cycles without ack before the block enters ERROR.
- CNT_W, 32: width of stall_cnt_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  core run enable.
- IDrs1_i  in  5  rs1 of the instruction in ID.
- IDrs2_i  in  5  rs2 of the instruction in ID.
- EXrd_i  in  5  rd of the instruction in EX.
- EXMemRead_i  in  1  instruction in EX is a load.
- BranchTaken_i  in  1  branch in ID resolved taken.
- MEMMemRead_i  in  1  instruction in MEM is a load.
- MEMMemWrite_i  in  1  instruction in MEM is a store.
- mem_ack_i  in  1  data memory completion, single-cycle pulse.
- mem_req_o  out  1  data memory request, registered.
- Stall_o  out  1  to Control Stall_i; inserts a bubble into ID/EX.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- IFIDFlush_o  out  1  zero the IF/ID register.
- pipe_hold_o  out  1  freeze all pipeline registers.
- err_o  out  1  sticky memory timeout flag.
- stall_cnt_o  out  CNT_W  saturating count of cycles with PCWrite_o=0 while start_i=1.

Behaviour:
Reset (rst_i=0, asynchronous):
- state=RUN, mem_req_o=0, err_o=0, stall_cnt_o=0, timeout counter=0.
- Combinational outputs with start_i=0: PCWrite_o=0, IFIDWrite_o=0; all other outputs 0.

start_i=0:
- No state transitions.
- PCWrite_o=0, IFIDWrite_o=0.
- stall_cnt_o holds.

FSM states: RUN, MEM_WAIT, MEM_DONE, ERROR.
- RUN: if MEMMemRead_i|MEMMemWrite_i, then pipe_hold_o=1 this cycle and the next state is MEM_WAIT. mem_req_o is set at that edge.
- MEM_WAIT: mem_req_o=1, pipe_hold_o=1, timeout counter increments each cycle.
  - mem_ack_i=1: go to MEM_DONE, clear mem_req_o, clear the counter.
  - Counter reaches TIMEOUT-1 without ack: go to ERROR.
- MEM_DONE: pipe_hold_o=0 for exactly one cycle so the pipeline advances; MEM is never re-evaluated in this cycle. Next state is RUN.
- ERROR: pipe_hold_o=1, err_o=1, mem_req_o=0. Exits only on reset.
- Latency: a memory op with ack in the first MEM_WAIT cycle costs 3 cycles, i.e. 2 stall cycles. Ack after k MEM_WAIT cycles costs 2+k cycles.
- mem_ack_i is ignored in RUN, MEM_DONE and ERROR.

Combinational priority, with start_i=1:
1. pipe_hold_o=1: PCWrite_o=0, IFIDWrite_o=0, Stall_o=0, IFIDFlush_o=0. The pipeline is frozen, so no bubble is inserted.
2. Load-use hazard: EXMemRead_i & EXrd_i≠0 & (EXrd_i==IDrs1_i | EXrd_i==IDrs2_i).
   - Stall_o=1, PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0.
   - A simultaneous BranchTaken_i is suppressed; the branch re-resolves next cycle.
3. BranchTaken_i: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1.
4. Otherwise: PCWrite_o=1, IFIDWrite_o=1, Stall_o=0, IFIDFlush_o=0.

stall_cnt_o:
- Increments at the clock edge when start_i=1 and PCWrite_o=0.
- Saturates at all-ones.

Reset mid-operation: asserting rst_i in MEM_WAIT immediately drops mem_req_o and returns the FSM to RUN.

Decomposition:
- Shared package hazard_pkg:
  - state encoding RUN=2'b00, MEM_WAIT=2'b01, MEM_DONE=2'b10, ERROR=2'b11;
  - REG_W=5;
  - TIMEOUT default.
- One sub-module, mem_stall_fsm:
  - contains the FSM, timeout counter and mem_req_o register;
  - outputs hold and err;
  - the top level adds hazard/flush logic and the performance counter.

Test Plan:
- Reset then start_i=1, no hazards: PCWrite_o=1, IFIDWrite_o=1, Stall_o=0, stall_cnt_o stays 0.
- Load-use: EXMemRead_i=1, EXrd_i=5, IDrs2_i=5 for 1 cycle → Stall_o=1, PCWrite_o=0 that cycle, stall_cnt_o=1. Repeat with EXrd_i=0 → no stall.
- Store in MEM, ack 3 cycles after mem_req_o rises:
  - pipe_hold_o high for 1+3 cycles, then low in MEM_DONE;
  - mem_req_o high exactly 3 cycles;
  - stall_cnt_o=4.
- BranchTaken_i=1 with a simultaneous load-use hazard → IFIDFlush_o=0, Stall_o=1. Next cycle, hazard cleared with branch still taken → IFIDFlush_o=1.
- Timeout with TIMEOUT=8, ack never sent:
  - err_o rises after 8 MEM_WAIT cycles and pipe_hold_o stays 1;
  - a late ack has no effect;
  - rst_i=0 clears err_o and returns the FSM to RUN.
- rst_i pulsed low during MEM_WAIT: mem_req_o=0 asynchronously; after release the next memory op starts a fresh handshake.
